// File: rtl/cw_stream_scheduler.sv
// cw_stream_scheduler: buffers variable-length codewords in a small FIFO, puts a
// frame-sync header in front of the first codeword of each frame, and
// serialises everything MSB first onto one bit lane under valid/ready.
// Optional zero-bit stuffing after seven ones in the payload is enabled by
// defining CW_STREAM_SCHEDULER_BIT_STUFF_EN.
module cw_stream_scheduler #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          CW_W       = 16,
    parameter int          LEN_W      = 5,
    parameter logic [15:0] HDR_CODE   = 16'hFF00
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [CW_W-1:0]  CW_IN,
    input  logic [LEN_W-1:0] CWL_IN,
    input  logic             VC_IN,
    input  logic             NEW_FRAME,
    output logic             OB,
    output logic             OB_VALID,
    input  logic             OB_READY,
    output logic             FIFO_FULL,
    output logic             OVERFLOW,
    output logic             BUSY
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + CW_W + LEN_W;
    localparam int CNT_W = (CW_W > 16) ? $clog2(CW_W) : 4;
    localparam logic [CNT_W-1:0] HDR_TOP = CNT_W'(15);

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, push_req, push, pop, drop, pending, tag_in;
    logic [LEN_W-1:0] len_in;
    logic [ENT_W-1:0] head;
    logic             head_tag;
    logic [CW_W-1:0]  head_cw;
    logic [LEN_W-1:0] head_len;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CW_W-1:0]  cur_word, cur_word_n;
    logic [LEN_W-1:0] cur_len, cur_len_n;
    logic             accept, load, adv, sel_bit, ob_n, obv_n;
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
    logic             stuff, stuff_n;
    logic [2:0]       run, run_n;
`endif

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req  = VC_IN && (CWL_IN != '0);
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign tag_in    = pending || NEW_FRAME;
    assign len_in    = (CWL_IN > LEN_W'(CW_W)) ? LEN_W'(CW_W) : CWL_IN;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_tag  = head[ENT_W-1];
    assign head_cw   = head[LEN_W +: CW_W];
    assign head_len  = head[LEN_W-1:0];
    assign accept    = OB_VALID && OB_READY;
    assign FIFO_FULL = full;
    assign BUSY      = (state != IDLE) || !empty;

    // Next-state, bit counter, held entry and the registered-output values
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cur_word_n = cur_word;
        cur_len_n  = cur_len;
        pop        = 1'b0;
        load       = 1'b0;
        adv        = 1'b0;
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
        stuff_n    = stuff;
        run_n      = run;
`endif
        case (state)
            IDLE: load = !empty;
            HEADER: begin
                if (accept) begin
                    if (cnt == '0) begin
                        state_n = DATA;
                        cnt_n   = CNT_W'(cur_len - LEN_W'(1));
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
                        run_n   = '0;
`endif
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (accept) begin
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
                    // The stuffed zero keeps cnt on the bit that preceded it
                    if (stuff) begin
                        stuff_n = 1'b0;
                        run_n   = '0;
                        adv     = 1'b1;
                    end else if (cur_word[cnt]) begin
                        run_n = run + 3'd1;
                        if (run == 3'd6) stuff_n = 1'b1;
                        else             adv     = 1'b1;
                    end else begin
                        run_n = '0;
                        adv   = 1'b1;
                    end
`else
                    adv = 1'b1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase

        if (adv) begin
            if (cnt == '0) begin
                if (!empty) load    = 1'b1;
                else        state_n = IDLE;
            end else begin
                cnt_n = cnt - CNT_W'(1);
            end
        end

        // Taking the head in the same edge that ends a codeword avoids bubbles
        if (load) begin
            pop        = 1'b1;
            cur_word_n = head_cw;
            cur_len_n  = head_len;
            if (head_tag) begin
                state_n = HEADER;
                cnt_n   = HDR_TOP;
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
                run_n   = '0;
`endif
            end else begin
                state_n = DATA;
                cnt_n   = CNT_W'(head_len - LEN_W'(1));
            end
        end

        sel_bit = (state_n == HEADER) ? HDR_CODE[cnt_n] : cur_word_n[cnt_n];
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
        ob_n    = (state_n != IDLE) && sel_bit && !stuff_n;
`else
        ob_n    = (state_n != IDLE) && sel_bit;
`endif
        obv_n   = (state_n != IDLE);
    end

    // Control state: FSM, pointers, flags and the registered output lane
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OB       <= 1'b0;
            OB_VALID <= 1'b0;
            OVERFLOW <= 1'b0;
            pending  <= 1'b0;
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
            stuff    <= 1'b0;
            run      <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            OB       <= ob_n;
            OB_VALID <= obv_n;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop) OVERFLOW <= 1'b1;
            if (push)           pending <= 1'b0;
            else if (NEW_FRAME) pending <= 1'b1;
`ifdef CW_STREAM_SCHEDULER_BIT_STUFF_EN
            stuff    <= stuff_n;
            run      <= run_n;
`endif
        end
    end

    // Datapath storage: FIFO entries and the codeword being serialised
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {tag_in, CW_IN, len_in};
        cur_word <= cur_word_n;
        cur_len  <= cur_len_n;
    end
endmodule
